mux_nway_reg: RTL and testbench

Parametrised N-way, W-bit registered multiplexer with a valid/ready handshake on every input channel and on the output. It generalises the fixed 4-way 32-bit combinational mux into a pipeline stage. It sits between multiple producers (register-file read ports, forwarding paths, load return) and a single consumer. Selection is either externally steered by `sel` or, when compiled in, round-robin among valid channels.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_pick.sv | 40 ++++
 rtl/mux_nway_reg.sv | 131 +++++++++++++
 tb/tb_mux_nway_reg.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-way registered multiplexer.
// Round-robin arbitration is enabled by defining MUXN_RR_EN.
package mux_pkg;

    localparam int unsigned MUXN_MAX_WAYS = 16;

    // Select width for a given channel count (at least one bit).
    function automatic int unsigned sel_width(input int unsigned ways);
        return (ways <= 1) ? 1 : $clog2(ways);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
// Only built when MUXN_RR_EN is defined; the steered build does not need it.
`ifdef MUXN_RR_EN
module rr_pick
    import mux_pkg::*;
#(
    parameter int unsigned WAYS = 4,
    parameter int unsigned SELW = sel_width(WAYS)
) (
    input  logic [WAYS-1:0] req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [SELW-1:0] grant_o,
    output logic            any_o
);

    logic [WAYS-1:0] rot_c;
    int unsigned     idx_c;

    // Rotate requests so bit k is the channel k places above ptr.
    assign rot_c = WAYS'({req_i, req_i} >> ptr_i);

    // Take the lowest rotated requester; with no requester the grant rests on ptr.
    always_comb begin
        grant_o = ptr_i;
        any_o   = 1'b0;
        idx_c   = 0;
        for (int unsigned k = 0; k < WAYS; k++) begin
            if (!any_o && rot_c[k]) begin
                any_o = 1'b1;
                idx_c = 32'(ptr_i) + k;
                if (idx_c >= WAYS) begin
                    idx_c = idx_c - WAYS;
                end
                grant_o = SELW'(idx_c);
            end
        end
    end

endmodule
`endif

// File: rtl/mux_nway_reg.sv
// N-way, W-bit registered multiplexer with valid/ready on every channel.
// Grant comes from sel by default; defining MUXN_RR_EN switches to
// round-robin arbitration among valid channels with an internal pointer.
module mux_nway_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned WAYS  = 4,
    parameter int unsigned SELW  = sel_width(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WAYS*WIDTH-1:0] in_data,
    input  logic [WAYS-1:0]       in_valid,
    output logic [WAYS-1:0]       in_ready,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SELW-1:0]       out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] ch_data_c [WAYS];
    logic [WIDTH-1:0] grant_data_c;
    logic [SELW-1:0]  grant_c;
    logic             grant_vld_c;
    logic             grant_ok_c;
    logic             load_c;
    logic             accept_c;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;

    // Unpack channel data into an array.
    for (genvar i = 0; i < WAYS; i++) begin : g_unpack
        assign ch_data_c[i] = in_data[i*WIDTH +: WIDTH];
    end

`ifdef MUXN_RR_EN
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            rr_any_c;

    rr_pick #(
        .WAYS (WAYS),
        .SELW (SELW)
    ) u_rr_pick (
        .req_i   (in_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_c),
        .any_o   (rr_any_c)
    );

    assign accept_c = !rst && load_c && grant_ok_c && rr_any_c && grant_vld_c;

    // Pointer moves just past the granted channel on every acceptance.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_c) begin
            ptr_d = (32'(grant_c) == WAYS - 1) ? '0 : grant_c + SELW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign grant_c  = sel;
    assign accept_c = !rst && load_c && grant_ok_c && grant_vld_c;
`endif

    assign grant_ok_c = (32'(grant_c) < WAYS);
    assign load_c     = !out_valid_q || out_ready;

    // Route the granted channel's data and valid; out-of-range grants read as idle.
    always_comb begin
        grant_data_c = '0;
        grant_vld_c  = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (grant_c == SELW'(i)) begin
                grant_data_c = ch_data_c[i];
                grant_vld_c  = in_valid[i];
            end
        end
    end

    // At most one ready bit, only when the stage can load and not in reset.
    always_comb begin
        in_ready = '0;
        if (!rst && load_c && grant_ok_c) begin
            in_ready = WAYS'(1) << grant_c;
        end
    end

    // Output register next state: refill on accept, drain when idle, hold on stall.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (load_c) begin
            out_valid_d = accept_c;
            if (accept_c) begin
                out_data_d = grant_data_c;
                out_sel_d  = grant_c;
            end
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nway_reg.sv
// Self-checking bench for mux_nway_reg: table vectors plus hand sequences,
// with a one-deep scoreboard modelling the output register.
module tb_mux_nway_reg;

    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main DUT, WAYS=4
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid, in_ready;
    logic [1:0]     sel, out_sel;
    logic [W-1:0]   out_data;
    logic           out_valid, out_ready;

    // Second DUT, WAYS=3, for out-of-range select
    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3, in_ready3;
    logic [1:0]     sel3, out_sel3;
    logic [W-1:0]   out_data3;
    logic           out_valid3, out_ready3;

    mux_nway_reg #(.WIDTH(W), .WAYS(N)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nway_reg #(.WIDTH(W), .WAYS(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .sel(sel3), .out_data(out_data3), .out_sel(out_sel3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    typedef struct {
        logic [W-1:0] data;
        int           sel;
    } beat_t;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        ordy;
        logic [31:0] base;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
    } vec_t;

    beat_t sb[$];
    int    sel_log[$];
    int    errors = 0;
    int    checks = 0;
    int    m_ptr  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < N; i++) in_data[i*W +: W] = base + 32'(i);
    endtask

    function automatic int model_grant();
`ifdef MUXN_RR_EN
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (in_valid[idx]) return idx;
        end
        return m_ptr;
`else
        return int'(sel);
`endif
    endfunction

    // Compare DUT against the model for this cycle, then advance the model
    // to what the coming rising edge should produce.
    task automatic check_now();
        int          g;
        logic [N-1:0] exp_rdy;
        logic        m_load;
        beat_t       b;
        m_load  = (sb.size() == 0) || out_ready;
        g       = model_grant();
        exp_rdy = '0;
        if (!rst && m_load && g < N) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (out_valid) sel_log.push_back(int'(out_sel));
        if (sb.size() != 0 && out_ready) begin
            b = sb.pop_front();
            chk("out_data", out_data, b.data);
            chk("out_sel", 32'(out_sel), 32'(b.sel));
        end
        if (rst) begin
            sb.delete();
            m_ptr = 0;
        end else if (m_load && g < N && in_valid[g]) begin
            b.data = in_data[g*W +: W];
            b.sel  = g;
            sb.push_back(b);
            m_ptr = (g == N - 1) ? 0 : g + 1;
        end
    endtask

    // One clock: inputs are already driven; check mid-cycle, return just after the edge.
    task automatic step();
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [8];
        int   exp_log [9];

        tbl[0] = '{2'd2, 4'b0100, 1'b1, 32'hDEADBEED, 4'b0100, 1'b0};
        tbl[1] = '{2'd0, 4'b0000, 1'b1, 32'h0000_0000, 4'b0001, 1'b1};
        tbl[2] = '{2'd1, 4'b0010, 1'b0, 32'h0000_1000, 4'b0010, 1'b0};
        tbl[3] = '{2'd3, 4'b1000, 1'b0, 32'h0000_1000, 4'b0000, 1'b1};
        tbl[4] = '{2'd3, 4'b1000, 1'b1, 32'h0000_2000, 4'b1000, 1'b1};
        tbl[5] = '{2'd3, 4'b0000, 1'b1, 32'h0000_2000, 4'b1000, 1'b1};
        tbl[6] = '{2'd0, 4'b1111, 1'b1, 32'h0000_3000, 4'b0001, 1'b0};
        tbl[7] = '{2'd1, 4'b1111, 1'b1, 32'h0000_3000, 4'b0010, 1'b1};

        rst = 1'b1; in_valid = '0; sel = '0; out_ready = 1'b1; set_data(32'h0);
        in_valid3 = '0; sel3 = '0; out_ready3 = 1'b1;
        in_data3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0;
        chk("reset out_data", out_data, 32'h0);
        chk("reset out_sel", 32'(out_sel), 32'h0);
        chk("reset out_valid3", 32'(out_valid3), 32'h0);

        // Table-driven vectors
        foreach (tbl[i]) begin
            sel = tbl[i].sel; in_valid = tbl[i].valid; out_ready = tbl[i].ordy;
            set_data(tbl[i].base);
            @(negedge clk);
`ifndef MUXN_RR_EN
            chk("tbl in_ready", 32'(in_ready), 32'(tbl[i].exp_rdy));
`endif
            chk("tbl out_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
            check_now();
            @(posedge clk); #1;
        end
        in_valid = '0; out_ready = 1'b1;
        step();

        // Backpressure: held beat survives a 3-cycle stall, then ch1 follows
        sel = 2'd0; in_valid = 4'b0001; set_data(32'h4000);
        step();
        sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
        repeat (3) begin
            step();
            chk("bp hold data", out_data, 32'h4000);
            chk("bp in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        step();
        chk("bp next data", out_data, 32'h4001);
        in_valid = '0;
        step();
        step();

`ifndef MUXN_RR_EN
        // Out-of-range select on the 3-way instance
        in_valid3 = 3'b111; sel3 = 2'd0; out_ready3 = 1'b1;
        step();
        sel3 = 2'd3; out_ready3 = 1'b0;
        step();
        chk("oor held valid", 32'(out_valid3), 32'h1);
        chk("oor held data", out_data3, 32'h3333_0000);
        chk("oor in_ready stall", 32'(in_ready3), 32'h0);
        out_ready3 = 1'b1;
        #1;
        chk("oor in_ready load", 32'(in_ready3), 32'h0);
        step();
        chk("oor drained", 32'(out_valid3), 32'h0);
        chk("oor in_ready idle", 32'(in_ready3), 32'h0);
        step();
        chk("oor stays empty", 32'(out_valid3), 32'h0);
        in_valid3 = '0;
`endif

        // Reset while a beat is held
        sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1; set_data(32'h12345678);
        step();
        chk("pre-rst valid", 32'(out_valid), 32'h1);
        chk("pre-rst data", out_data, 32'h12345678);
        rst = 1'b1; out_ready = 1'b0; in_valid = 4'b1111;
        step();
        rst = 1'b0; in_valid = '0; out_ready = 1'b1;
        chk("post-rst valid", 32'(out_valid), 32'h0);
        chk("post-rst data", out_data, 32'h0);
        chk("post-rst sel", 32'(out_sel), 32'h0);
        step();

`ifdef MUXN_RR_EN
        // Round-robin ordering: all valid, then only ch3 and ch1 from ptr=2
        exp_log = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
        sel_log.delete();
        in_valid = 4'b1111; set_data(32'h5000);
        repeat (6) step();
        in_valid = 4'b1010;
        repeat (3) step();
        in_valid = '0;
        step();
        step();
        chk("rr log length", 32'(sel_log.size()), 32'd9);
        for (int i = 0; i < 9 && i < sel_log.size(); i++)
            chk("rr out_sel order", 32'(sel_log[i]), 32'(exp_log[i]));
`else
        exp_log = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

        // Full throughput with random data
        out_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            sel = 2'($urandom_range(0, 3));
            in_valid = 4'($urandom);
            in_valid[sel] = 1'b1;
            for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
            step();
        end
        in_valid = '0;
        step();
        step();
        chk("scoreboard drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
